// File: rtl/game_pkg.sv
// Shared tile-map game constants: map geometry, wall sentinel and collision bit layout.
package game_pkg;

  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned MAP_COLS   = 15;
  localparam int unsigned MAP_ROWS   = 10;
  localparam int unsigned HERO_SIZE  = 48;
  localparam int unsigned STEP       = 1;
  localparam int unsigned X_INIT     = 0;
  localparam int unsigned Y_INIT     = 0;
  localparam int unsigned X_MAX      = MAP_COLS * BLOCK_SIZE - HERO_SIZE;
  localparam int unsigned Y_MAX      = MAP_ROWS * BLOCK_SIZE - HERO_SIZE;

  localparam int unsigned POS_W   = 12;
  localparam int unsigned ARITH_W = 13;
  localparam int unsigned COL_W   = 4;

  localparam logic [POS_W-1:0] NO_WALL = 12'hFFF;

  localparam int unsigned COL_UP    = 0;
  localparam int unsigned COL_DOWN  = 1;
  localparam int unsigned COL_LEFT  = 2;
  localparam int unsigned COL_RIGHT = 3;

endpackage

// File: rtl/hero_wall_check.sv
// Combinational test of the hero box shifted one STEP in each direction against one wall box.
module hero_wall_check
  import game_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = game_pkg::BLOCK_SIZE,
  parameter int unsigned HERO_SIZE  = game_pkg::HERO_SIZE,
  parameter int unsigned STEP       = game_pkg::STEP
) (
  input  logic [POS_W-1:0] hero_x,
  input  logic [POS_W-1:0] hero_y,
  input  logic [POS_W-1:0] block_x,
  input  logic [POS_W-1:0] block_y,
  output logic [COL_W-1:0] blocked_c
);

  localparam logic [ARITH_W-1:0] B = ARITH_W'(BLOCK_SIZE);
  localparam logic [ARITH_W-1:0] H = ARITH_W'(HERO_SIZE);
  localparam logic [ARITH_W-1:0] S = ARITH_W'(STEP);

  logic [ARITH_W-1:0] hx, hy, bx, by;
  logic               x_ovl, y_ovl;

  // Left/up shifts are moved to the wall side of each compare so nothing underflows.
  always_comb begin
    hx = ARITH_W'(hero_x);
    hy = ARITH_W'(hero_y);
    bx = ARITH_W'(block_x);
    by = ARITH_W'(block_y);
    x_ovl = (hx < bx + B) && (hx + H > bx);
    y_ovl = (hy < by + B) && (hy + H > by);
    blocked_c = '0;
    blocked_c[COL_RIGHT] = y_ovl && (hx + H + S > bx) && (hx + S < bx + B);
    blocked_c[COL_LEFT]  = y_ovl && (hx < bx + B + S) && (hx + H > bx + S);
    blocked_c[COL_DOWN]  = x_ovl && (hy + H + S > by) && (hy + S < by + B);
    blocked_c[COL_UP]    = x_ovl && (hy < by + B + S) && (hy + H > by + S);
  end

endmodule

// File: rtl/hero_ctl.sv
// Hero position controller: accumulates wall collisions over a frame and steps on each movement tick.
// Define HERO_CENTER_EN to let center=1 on a tick respawn the hero at (X_INIT, Y_INIT).
module hero_ctl
  import game_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = game_pkg::BLOCK_SIZE,
  parameter int unsigned HERO_SIZE  = game_pkg::HERO_SIZE,
  parameter int unsigned STEP       = game_pkg::STEP,
  parameter int unsigned X_INIT     = game_pkg::X_INIT,
  parameter int unsigned Y_INIT     = game_pkg::Y_INIT,
  parameter int unsigned X_MAX      = game_pkg::X_MAX,
  parameter int unsigned Y_MAX      = game_pkg::Y_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             up,
  input  logic             left,
  input  logic             right,
  input  logic             down,
  input  logic             center,
  input  logic [POS_W-1:0] block_x_pos,
  input  logic [POS_W-1:0] block_y_pos,
  output logic [COL_W-1:0] collision,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos
);

  logic             clk_div_q, clk_div_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [COL_W-1:0] blocked_c;
  logic             tick_c;
  logic             respawn_c;

`ifdef HERO_CENTER_EN
  assign respawn_c = center;
`else
  logic unused_center;
  assign unused_center = center;
  assign respawn_c     = 1'b0;
`endif

  hero_wall_check #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .HERO_SIZE (HERO_SIZE),
    .STEP      (STEP)
  ) u_wall_check (
    .hero_x   (x_q),
    .hero_y   (y_q),
    .block_x  (block_x_pos),
    .block_y  (block_y_pos),
    .blocked_c(blocked_c)
  );

  // The tick clear takes priority over the wall OR-in of the same clock.
  always_comb begin
    clk_div_d = clk_div;
    tick_c    = clk_div & ~clk_div_q;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    if (block_x_pos != NO_WALL) col_d = col_q | blocked_c;
    if (tick_c) begin
      col_d = '0;
      if (respawn_c) begin
        x_d = POS_W'(X_INIT);
        y_d = POS_W'(Y_INIT);
      end else if (up) begin
        if (!col_q[COL_UP] && y_q >= POS_W'(STEP)) y_d = y_q - POS_W'(STEP);
      end else if (down) begin
        if (!col_q[COL_DOWN] && y_q <= POS_W'(Y_MAX - STEP)) y_d = y_q + POS_W'(STEP);
      end else if (left) begin
        if (!col_q[COL_LEFT] && x_q >= POS_W'(STEP)) x_d = x_q - POS_W'(STEP);
      end else if (right) begin
        if (!col_q[COL_RIGHT] && x_q <= POS_W'(X_MAX - STEP)) x_d = x_q + POS_W'(STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_div_q <= 1'b0;
      x_q       <= POS_W'(X_INIT);
      y_q       <= POS_W'(Y_INIT);
      col_q     <= '0;
    end else begin
      clk_div_q <= clk_div_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
    end
  end

  assign collision = col_q;
  assign x_pos     = x_q;
  assign y_pos     = y_q;

endmodule

// File: tb/tb_hero_ctl.sv
// Scoreboard bench for hero_ctl: frames of wall blocks then a movement tick, checked against a box-geometry model.
module tb_hero_ctl;

  localparam int BS = 64;
  localparam int HS = 48;
  localparam int ST = 1;
  localparam int XM = 912;
  localparam int YM = 592;
`ifdef HERO_CENTER_EN
  localparam bit CENTER_ON = 1'b1;
`else
  localparam bit CENTER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clk_div, up, left, right, down, center;
  logic [11:0] block_x_pos, block_y_pos;
  logic [3:0]  collision;
  logic [11:0] x_pos, y_pos;

  always #5 clk = ~clk;

  hero_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .up         (up),
    .left       (left),
    .right      (right),
    .down       (down),
    .center     (center),
    .block_x_pos(block_x_pos),
    .block_y_pos(block_y_pos),
    .collision  (collision),
    .x_pos      (x_pos),
    .y_pos      (y_pos)
  );

  typedef struct {
    int col;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   wx[$];
  int   wy[$];
  int   total = 0;
  int   bad   = 0;
  int   mx    = 0;
  int   my    = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit boxes_hit(input int ax, input int ay, input int bx, input int by);
    return (ax < bx + BS) && (ax + HS > bx) && (ay < by + BS) && (ay + HS > by);
  endfunction

  // Each direction bit: the hero box translated one step that way overlaps some wall of the frame.
  function automatic int model_col(input int x, input int y);
    int r = 0;
    foreach (wx[i]) begin
      if (boxes_hit(x, y - ST, wx[i], wy[i])) r |= 1;
      if (boxes_hit(x, y + ST, wx[i], wy[i])) r |= 2;
      if (boxes_hit(x - ST, y, wx[i], wy[i])) r |= 4;
      if (boxes_hit(x + ST, y, wx[i], wy[i])) r |= 8;
    end
    return r;
  endfunction

  task automatic frame(input bit u, input bit d, input bit l, input bit r, input bit c);
    int   col;
    int   nx;
    int   ny;
    exp_t e;
    col = model_col(mx, my);
    up = u; down = d; left = l; right = r; center = c;
    foreach (wx[i]) begin
      block_x_pos = 12'(wx[i]);
      block_y_pos = 12'(wy[i]);
      @(posedge clk); #1;
    end
    block_x_pos = 12'hFFF;
    block_y_pos = 12'h000;
    nx = mx;
    ny = my;
    if (c && CENTER_ON) begin
      nx = 0; ny = 0;
    end else if (u) begin
      if ((col & 1) == 0 && my - ST >= 0) ny = my - ST;
    end else if (d) begin
      if ((col & 2) == 0 && my + ST <= YM) ny = my + ST;
    end else if (l) begin
      if ((col & 4) == 0 && mx - ST >= 0) nx = mx - ST;
    end else if (r) begin
      if ((col & 8) == 0 && mx + ST <= XM) nx = mx + ST;
    end
    e.col = col; e.x = nx; e.y = ny;
    sb.push_back(e);
    mx = nx;
    my = ny;
    clk_div = 1'b1;
    @(posedge clk); #1;
    clk_div = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("rst_x", int'(x_pos), 0);
    check("rst_y", int'(y_pos), 0);
    check("rst_col", int'(collision), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mx = 0;
    my = 0;
    @(posedge clk); #1;
  endtask

  // Monitor: clk_div high marks the clock before the tick edge; collision is read then, position one clock later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clk_div === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty actual=tick required=expectation at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("collision", int'(collision), e.col);
          @(negedge clk);
          check("x_pos", int'(x_pos), e.x);
          check("y_pos", int'(y_pos), e.y);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v;
    rst = 1'b1; clk_div = 1'b0;
    up = 0; down = 0; left = 0; right = 0; center = 0;
    block_x_pos = 12'hFFF; block_y_pos = 12'h000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    repeat (5) frame(0, 0, 1, 0, 0);
    repeat (5) frame(1, 0, 0, 0, 0);
    check("bound_origin_x", int'(x_pos), 0);
    check("bound_origin_y", int'(y_pos), 0);

    repeat (10) frame(0, 0, 0, 1, 0);
    check("free_move_x", int'(x_pos), 10);

    wx.push_back(128); wy.push_back(0);
    repeat (100) frame(0, 0, 0, 1, 0);
    check("wall_stop_x", int'(x_pos), 80);
    wx.delete(); wy.delete();

    repeat (840) frame(0, 0, 0, 1, 0);
    check("bound_xmax", int'(x_pos), 912);
    repeat (5) frame(0, 0, 0, 1, 0);
    check("bound_xmax_hold", int'(x_pos), 912);

    do_reset();
    repeat (10) frame(0, 1, 0, 0, 0);
    repeat (3) frame(1, 0, 0, 1, 0);
    check("prio_x", int'(x_pos), 0);
    check("prio_y", int'(y_pos), 7);

`ifdef HERO_CENTER_EN
    do_reset();
    repeat (40) frame(0, 0, 0, 1, 0);
    repeat (20) frame(0, 1, 0, 0, 0);
    frame(0, 0, 0, 1, 1);
    check("respawn_x", int'(x_pos), 0);
    check("respawn_y", int'(y_pos), 0);
`endif

    do_reset();
    for (int k = 0; k < 400; k++) begin
      wx.delete(); wy.delete();
      n = $urandom_range(0, 4);
      for (int j = 0; j < n; j++) begin
        v = mx + $urandom_range(0, 200) - 100;
        wx.push_back(v < 0 ? 0 : v);
        v = my + $urandom_range(0, 200) - 100;
        wy.push_back(v < 0 ? 0 : v);
      end
      frame($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 7) == 0);
    end
    wx.delete(); wy.delete();

    repeat (4) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
